// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if
//   Bundles the writeback requester handshake, the HOLD control and the
//   register bank write port into one interface.
//   Modports:
//     slave  : the arbiter side (takes requests and HOLD, drives READY and
//              the registered write port).
//     master : the requester/controller side (drives requests and HOLD).
//   Signals:
//     REQ_VALID [NREQ]         request pending, one bit per requester
//     REQ_ADDR  [NREQ*ADDR_W]  packed destination addresses
//     REQ_DATA  [NREQ*WIDTH]   packed write data
//     REQ_READY [NREQ]         one-hot or zero accept strobe
//     HOLD                     blocks every grant this cycle
//     WE3/RA3/WD3              registered bank write port
//     GRANT_ID                 registered index of the current writer
//     CONFLICT                 registered same-address pulse
interface reg_write_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4,
  parameter int GID_W  = 2
);
  logic [NREQ-1:0]        REQ_VALID;
  logic [NREQ*ADDR_W-1:0] REQ_ADDR;
  logic [NREQ*WIDTH-1:0]  REQ_DATA;
  logic [NREQ-1:0]        REQ_READY;
  logic                   HOLD;
  logic                   WE3;
  logic [ADDR_W-1:0]      RA3;
  logic [WIDTH-1:0]       WD3;
  logic [GID_W-1:0]       GRANT_ID;
  logic                   CONFLICT;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
    output REQ_READY, WE3, RA3, WD3, GRANT_ID, CONFLICT
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_DATA, HOLD,
    input  REQ_READY, WE3, RA3, WD3, GRANT_ID, CONFLICT
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Shares the register bank's single write port among NREQ writeback
//   requesters. Round-robin arbitration picks one valid requester per cycle
//   (combinational READY); the accepted write is registered once and drives
//   WE3/RA3/WD3 directly on the following cycle.
//   Ports:
//     CLK    clock, all state on posedge
//     RST_N  synchronous active-low reset
//     bus    reg_write_arbiter_if.slave (requests, HOLD, READY, write port,
//            GRANT_ID, CONFLICT)
//   Optional feature macro: REGWR_ZERO_DISCARD_EN
//     When defined, a request to address 0 is still arbitrated and accepted
//     but never raises WE3, so register 0 is never written.
//   GID_W must satisfy 2**GID_W >= NREQ; NREQ must be at least 2.

// Per-requester address compare against the current winner's address.
module rwa_lane #(
  parameter int ADDR_W = 5
) (
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] win_addr_i,
  output logic              match_o
);
  assign match_o = vld_i && (addr_i == win_addr_i);
endmodule

module reg_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 4,
  parameter int GID_W  = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  reg_write_arbiter_if.slave  bus
);

  localparam logic [GID_W:0]   NREQ_X = (GID_W+1)'(NREQ);
  localparam logic [GID_W-1:0] LAST   = GID_W'(NREQ - 1);

  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [WIDTH-1:0]  wd_q, wd_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic              conf_q, conf_d;

  logic              win_found;
  logic [GID_W-1:0]  win_idx;
  logic              grant;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_data;
  logic [NREQ-1:0]   match;
  logic              conflict;
  logic [NREQ-1:0]   ready;

  // Round-robin scan starting at ptr_q. The index is kept in GID_W+1 bits so
  // the wrap subtraction works for any NREQ, not just powers of two.
  always_comb begin
    logic [GID_W:0] sum;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + (GID_W+1)'(k);
      if (sum >= NREQ_X) sum = sum - NREQ_X;
      if (!win_found && bus.REQ_VALID[sum[GID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = sum[GID_W-1:0];
      end
    end
  end

  // READY is forced low during reset and while HOLD is asserted.
  assign grant = win_found && RST_N && !bus.HOLD;

  always_comb begin
    ready = '0;
    if (grant) ready[win_idx] = 1'b1;
  end
  assign bus.REQ_READY = ready;

  assign win_addr = bus.REQ_ADDR[win_idx*ADDR_W +: ADDR_W];
  assign win_data = bus.REQ_DATA[win_idx*WIDTH +: WIDTH];

  // The winner always matches itself, so a conflict means at least two
  // matching lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    rwa_lane #(.ADDR_W(ADDR_W)) u_lane (
      .vld_i      (bus.REQ_VALID[i]),
      .addr_i     (bus.REQ_ADDR[i*ADDR_W +: ADDR_W]),
      .win_addr_i (win_addr),
      .match_o    (match[i])
    );
  end
  assign conflict = ($countones(match) >= 2);

  // Next-state for the output stage and the priority pointer.
  always_comb begin
    we_d   = 1'b0;
    ra_d   = ra_q;
    wd_d   = wd_q;
    gid_d  = gid_q;
    conf_d = 1'b0;
    ptr_d  = ptr_q;
    if (grant) begin
      gid_d  = win_idx;
      conf_d = conflict;
      ptr_d  = (win_idx == LAST) ? '0 : win_idx + 1'b1;
`ifdef REGWR_ZERO_DISCARD_EN
      // Address 0 is accepted but dropped; the write port keeps its value.
      if (win_addr != '0) begin
        we_d = 1'b1;
        ra_d = win_addr;
        wd_d = win_data;
      end
`else
      we_d = 1'b1;
      ra_d = win_addr;
      wd_d = win_data;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      ra_q   <= '0;
      wd_q   <= '0;
      gid_q  <= '0;
      conf_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      ra_q   <= ra_d;
      wd_q   <= wd_d;
      gid_q  <= gid_d;
      conf_q <= conf_d;
    end
  end

  assign bus.WE3      = we_q;
  assign bus.RA3      = ra_q;
  assign bus.WD3      = wd_q;
  assign bus.GRANT_ID = gid_q;
  assign bus.CONFLICT = conf_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Directed scenarios with literal expectations, then a long randomized run
//   of protocol-obeying requesters. A behavioural model (rotation scan over
//   plain arrays) predicts READY every cycle and the write port after every
//   posedge.
module tb_reg_write_arbiter;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NREQ   = 4;
  localparam int GID_W  = 2;
`ifdef REGWR_ZERO_DISCARD_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREQ(NREQ), .GID_W(GID_W)) bus ();

  reg_write_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NREQ(NREQ), .GID_W(GID_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  // requester-side state
  logic              pv [NREQ];
  logic [ADDR_W-1:0] pa [NREQ];
  logic [WIDTH-1:0]  pd [NREQ];
  logic              hold;

  // model state
  int                m_ptr;
  logic              m_we;
  logic [ADDR_W-1:0] m_ra;
  logic [WIDTH-1:0]  m_wd;
  int                m_gid;
  logic              m_conf;
  int                wait_c [NREQ];
  int                last_win;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.REQ_VALID[i] = pv[i];
      bus.REQ_ADDR[i*ADDR_W +: ADDR_W] = pa[i];
      bus.REQ_DATA[i*WIDTH +: WIDTH] = pd[i];
    end
    bus.HOLD = hold;
  endtask

  // First valid requester found walking from the pointer around the ring.
  function automatic int model_winner();
    if (!rst_n || hold) return -1;
    for (int k = 0; k < NREQ; k++)
      if (pv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic tick();
    int w;
    int same;
    @(negedge clk);
    w = model_winner();
    chk("ready", {60'd0, bus.REQ_READY}, (w < 0) ? 64'd0 : (64'd1 << w));
    for (int i = 0; i < NREQ; i++) begin
      if (!rst_n || !pv[i]) wait_c[i] = 0;
      else if (!hold) begin
        if (w == i) begin
          chk("fair_wait", {63'd0, wait_c[i] < NREQ}, 64'd1);
          wait_c[i] = 0;
        end else wait_c[i]++;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_we = 0; m_ra = '0; m_wd = '0; m_gid = 0; m_conf = 0;
      w = -1;
    end else if (w >= 0) begin
      same = 0;
      for (int i = 0; i < NREQ; i++) if (pv[i] && pa[i] == pa[w]) same++;
      m_conf = (same >= 2);
      m_gid  = w;
      m_ptr  = (w + 1) % NREQ;
      m_we   = !(ZD && pa[w] == 0);
      if (m_we) begin m_ra = pa[w]; m_wd = pd[w]; end
    end else begin
      m_we = 0; m_conf = 0;
    end
    last_win = w;
    #1;
    chk("WE3", {63'd0, bus.WE3}, {63'd0, m_we});
    chk("RA3", {59'd0, bus.RA3}, {59'd0, m_ra});
    chk("WD3", {32'd0, bus.WD3}, {32'd0, m_wd});
    chk("GRANT_ID", {62'd0, bus.GRANT_ID}, 64'(m_gid));
    chk("CONFLICT", {63'd0, bus.CONFLICT}, {63'd0, m_conf});
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end
    hold = 0;
    apply();
  endtask

  task automatic do_reset();
    clear_reqs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) wait_c[i] = 0;
    m_ptr = 0; m_we = 0; m_ra = '0; m_wd = '0; m_gid = 0; m_conf = 0;
    last_win = -1;
    clear_reqs();

    // Reset with every requester valid.
    rst_n = 0;
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1; pa[i] = ADDR_W'(i + 1); pd[i] = 32'h100 + i; end
    apply();
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", {60'd0, bus.REQ_READY}, 64'd0);
      chk("rst_we", {63'd0, bus.WE3}, 64'd0);
      chk("rst_ra", {59'd0, bus.RA3}, 64'd0);
      chk("rst_wd", {32'd0, bus.WD3}, 64'd0);
      chk("rst_gid", {62'd0, bus.GRANT_ID}, 64'd0);
    end
    rst_n = 1;
    #1 chk("first_ready", {60'd0, bus.REQ_READY}, 64'h1);
    tick();
    chk("first_gid", {62'd0, bus.GRANT_ID}, 64'd0);
    chk("first_wd", {32'd0, bus.WD3}, 64'h100);

    // Single requester.
    do_reset();
    pv[2] = 1; pa[2] = 5'd7; pd[2] = 32'hDEAD_BEEF; apply();
    #1 chk("single_ready", {60'd0, bus.REQ_READY}, 64'h4);
    tick();
    chk("single_we", {63'd0, bus.WE3}, 64'd1);
    chk("single_ra", {59'd0, bus.RA3}, 64'd7);
    chk("single_wd", {32'd0, bus.WD3}, 64'hDEAD_BEEF);
    chk("single_gid", {62'd0, bus.GRANT_ID}, 64'd2);
    pv[2] = 0; apply();
    tick();
    chk("single_we_off", {63'd0, bus.WE3}, 64'd0);

    // Round robin with all four continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1; pa[i] = ADDR_W'(i + 8); pd[i] = $urandom; end
    apply();
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rr_gid", {62'd0, bus.GRANT_ID}, 64'(c % 4));
      chk("rr_we", {63'd0, bus.WE3}, 64'd1);
      pd[last_win] = $urandom; apply();
    end

    // HOLD for three cycles after the grant to requester 1.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin pv[i] = 1; pa[i] = ADDR_W'(i + 12); pd[i] = 32'h200 + i; end
    apply();
    tick();
    tick();
    chk("hold_pre_gid", {62'd0, bus.GRANT_ID}, 64'd1);
    hold = 1; apply();
    #1 chk("hold_ready", {60'd0, bus.REQ_READY}, 64'd0);
    chk("hold_we_still", {63'd0, bus.WE3}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_we", {63'd0, bus.WE3}, 64'd0);
    end
    hold = 0; apply();
    #1 chk("hold_rel_ready", {60'd0, bus.REQ_READY}, 64'h4);
    tick();
    chk("hold_rel_gid", {62'd0, bus.GRANT_ID}, 64'd2);

    // Same-address conflict.
    do_reset();
    pv[0] = 1; pa[0] = 5'd5; pd[0] = 32'h11;
    pv[1] = 1; pa[1] = 5'd5; pd[1] = 32'h22;
    apply();
    tick();
    chk("conf1_wd", {32'd0, bus.WD3}, 64'h11);
    chk("conf1_flag", {63'd0, bus.CONFLICT}, 64'd1);
    pv[0] = 0; apply();
    tick();
    chk("conf2_wd", {32'd0, bus.WD3}, 64'h22);
    chk("conf2_flag", {63'd0, bus.CONFLICT}, 64'd0);
    chk("conf2_we", {63'd0, bus.WE3}, 64'd1);

    // Address 0 request.
    do_reset();
    pv[0] = 1; pa[0] = '0; pd[0] = 32'h55; apply();
    #1 chk("zero_ready", {60'd0, bus.REQ_READY}, 64'h1);
    tick();
    chk("zero_gid", {62'd0, bus.GRANT_ID}, 64'd0);
    chk("zero_we", {63'd0, bus.WE3}, ZD ? 64'd0 : 64'd1);
    chk("zero_ra", {59'd0, bus.RA3}, 64'd0);
    chk("zero_wd", {32'd0, bus.WD3}, ZD ? 64'd0 : 64'h55);

    // Randomized requesters: hold a request until the model says accepted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (last_win >= 0) pv[last_win] = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1;
          pa[i] = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 31))
                                              : ADDR_W'($urandom_range(0, 2));
          pd[i] = $urandom;
        end
      end
      hold  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      apply();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
